// File: rtl/interest_packet_parser.sv
// Interest packet parser: takes "type, N, N prefix bytes" off a byte stream and
// presents the left-aligned name prefix to the PIT/FIB with a one-cycle strobe.
module interest_packet_parser #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        pit_ready,
    output logic [63:0] SPI_to_PIT_prefix,
    output logic [5:0]  len,
    output logic        out_bit,
    output logic        parse_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        GET_LEN,
        GET_PREFIX,
        EMIT
    } state_t;

    localparam logic [7:0] TYPE_INTEREST = 8'h05;
    localparam logic [7:0] MAX_PREFIX    = 8'd8;
    localparam logic [7:0] TIMEOUT_LAST  = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic [3:0]  r_n;
    logic [3:0]  r_cnt;
    logic [7:0]  r_timer;
    logic [63:0] r_shift;
    logic [63:0] r_prefix;
    logic [5:0]  r_len;
    logic        r_parse_error;

    logic        w_xfer;
    logic        w_in_packet;
    logic        w_hdr_err;
    logic        w_len_ok;
    logic        w_len_err;
    logic        w_timeout;
    logic        w_last_byte;
    logic [63:0] w_shift_next;

    assign w_xfer      = rx_valid && rx_ready;
    assign w_in_packet = (r_state == GET_LEN) || (r_state == GET_PREFIX);
    assign w_hdr_err   = (r_state == IDLE) && w_xfer && (rx_byte != TYPE_INTEREST);
    assign w_len_ok    = (rx_byte != 8'd0) && (rx_byte <= MAX_PREFIX);
    assign w_len_err   = (r_state == GET_LEN) && w_xfer && !w_len_ok;
    // The timer trips on the idle cycle that would carry it up to TIMEOUT.
    assign w_timeout   = w_in_packet && !w_xfer && (r_timer >= TIMEOUT_LAST);
    assign w_last_byte = (r_state == GET_PREFIX) && w_xfer && (r_cnt == (r_n - 4'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer && (rx_byte == TYPE_INTEREST)) begin
                    w_next_state = GET_LEN;
                end
            end
            GET_LEN: begin
                if (w_timeout || w_len_err) begin
                    w_next_state = IDLE;
                end else if (w_xfer) begin
                    w_next_state = GET_PREFIX;
                end
            end
            GET_PREFIX: begin
                if (w_timeout) begin
                    w_next_state = IDLE;
                end else if (w_last_byte) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                if (pit_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Reset masks the handshake and strobes combinationally so nothing leaks out mid-reset.
    always_comb begin
        rx_ready    = 1'b0;
        busy        = 1'b0;
        out_bit     = 1'b0;
        parse_error = 1'b0;
        if (!rst) begin
            rx_ready    = (r_state != EMIT);
            busy        = (r_state != IDLE);
            out_bit     = (r_state == EMIT) && pit_ready;
            parse_error = r_parse_error;
        end
    end

    assign SPI_to_PIT_prefix = r_prefix;
    assign len               = r_len;

    always_comb begin
        w_shift_next = r_shift;
        for (int i = 0; i < 8; i++) begin
            if (r_cnt == 4'(i)) begin
                w_shift_next[63 - 8*i -: 8] = rx_byte;
            end
        end
    end

    // Working shift register is separate from the published prefix so an
    // aborted packet never disturbs the last good outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n           <= 4'd0;
            r_cnt         <= 4'd0;
            r_shift       <= 64'd0;
            r_prefix      <= 64'd0;
            r_len         <= 6'd0;
            r_parse_error <= 1'b0;
        end else begin
            r_parse_error <= w_hdr_err || w_len_err || w_timeout;
            if ((r_state == GET_LEN) && w_xfer && w_len_ok) begin
                r_n     <= rx_byte[3:0];
                r_cnt   <= 4'd0;
                r_shift <= 64'd0;
            end else if ((r_state == GET_PREFIX) && w_xfer) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 4'd1;
            end
            if (w_last_byte) begin
                r_prefix <= w_shift_next;
                r_len    <= {2'b00, r_n};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= 8'd0;
        end else if (!w_in_packet || w_xfer || w_timeout) begin
            r_timer <= 8'd0;
        end else begin
            r_timer <= r_timer + 8'd1;
        end
    end

endmodule

// File: doc/interest_packet_parser.md
INTEREST_PACKET_PARSER -- requirements
Module: interest_packet_parser

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum idle cycles allowed between bytes of one packet (range 1..255).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 rx_byte  input  8  incoming SPI byte.
REQ-006 rx_valid  input  1  rx_byte valid this cycle; a byte transfers when rx_valid && rx_ready.
REQ-007 rx_ready  output  1  parser can accept a byte.
REQ-008 pit_ready  input  1  downstream PIT/FIB can take a prefix this cycle.
REQ-009 SPI_to_PIT_prefix  output  64  parsed name prefix, left-aligned, MSB first, zero-padded.
REQ-010 len  output  6  prefix length in bytes (1..8).
REQ-011 out_bit  output  1  one-cycle strobe: prefix and len valid.
REQ-012 parse_error  output  1  one-cycle strobe on malformed or aborted packet.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Packet format SHALL be: byte0 type, byte1 prefix byte count N, then N prefix bytes.
REQ-015 States SHALL be IDLE, GET_LEN, GET_PREFIX, EMIT.
REQ-016 IDLE: accepted byte 0x05 -> GET_LEN; any other accepted byte -> parse_error pulse next cycle, remain IDLE.
REQ-017 GET_LEN: accepted N in 1..8 -> latch N, clear prefix shift register, byte counter = 0, -> GET_PREFIX; N = 0 or N > 8 -> parse_error pulse, -> IDLE.
REQ-018 GET_PREFIX: each accepted byte SHALL be written to prefix bits [63-8k -: 8] for counter value k, then k increments; after byte k = N-1 -> EMIT.
REQ-019 Unwritten prefix bytes SHALL read 0.
REQ-020 rx_ready SHALL be 1 in IDLE, GET_LEN, GET_PREFIX and 0 in EMIT and during reset.
REQ-021 EMIT: out_bit SHALL assert for exactly one cycle, on the first cycle pit_ready is 1, then -> IDLE; prefix and len are held stable from EMIT entry until the next GET_LEN completes.
REQ-022 EMIT with pit_ready = 0 SHALL wait indefinitely with no timeout.
REQ-023 Latency: out_bit SHALL rise the cycle after the last prefix byte is accepted when pit_ready is 1.
REQ-024 Timeout counter SHALL reset to 0 on every accepted byte and on entering GET_LEN; it increments each cycle in GET_LEN/GET_PREFIX without a transfer; reaching TIMEOUT -> parse_error pulse, -> IDLE, partial prefix discarded (outputs keep last good values).
REQ-025 parse_error and out_bit SHALL never assert in the same cycle.
REQ-026 Byte counter SHALL be 4 bits wide and never exceed N.

Reset
REQ-027 On rst: state IDLE, SPI_to_PIT_prefix = 0, len = 0, out_bit = 0, parse_error = 0, busy = 0, rx_ready = 0, counters = 0.
REQ-028 rst SHALL take priority over all events, aborting any packet mid-parse with no out_bit or parse_error emitted.
REQ-029 rx_ready SHALL return to 1 the first cycle after rst deasserts.

Verification
REQ-030 Bytes 05 03 AA BB CC, pit_ready = 1 -> out_bit one cycle after CC; prefix = 0xAABBCC0000000000, len = 3.
REQ-031 Bytes 05 08 01..08 with pit_ready = 0 for 10 cycles -> rx_ready = 0 and busy = 1 throughout; out_bit on the first pit_ready = 1 cycle; prefix = 0x0102030405060708, len = 8.
REQ-032 Bytes 07, then 05 00, then 05 09 -> three parse_error pulses, no out_bit, IDLE after each.
REQ-033 With TIMEOUT = 4: bytes 05 02 AA, then 4 idle cycles -> parse_error; the following 05 01 11 yields prefix = 0x1100000000000000, len = 1.
REQ-034 rst asserted after 05 04 AA BB -> all outputs zero; the following 05 01 FF yields a correct single-byte prefix with no stale bytes.
